// File: rtl/cpu_step_controller.sv
// Multi-cycle sequencer for the single-cycle CPU datapath.
// Steps each instruction through FETCH/DECODE/EXECUTE/WRITEBACK and supports
// run, halt, single-step and a PC breakpoint. Counts retired instructions.
module cpu_step_controller #(
  parameter int PC_W    = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_i,
  input  logic               step_i,
  input  logic               halt_req_i,
  input  logic               resume_i,
  input  logic               bp_en_i,
  input  logic [PC_W-1:0]    bp_addr_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic               ctrl_regwrite_i,
  output logic               pc_en_o,
  output logic               ir_load_o,
  output logic               reg_we_o,
  output logic               busy_o,
  output logic               halted_o,
  output logic [2:0]         state_o,
  output logic [COUNT_W-1:0] instr_count_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    HALTED    = 3'd5
  } state_t;

  state_t          state, state_n;
  logic            mode, mode_n;     // 1 = continuous, 0 = single step
  logic            halt_pending;
  logic            step_q;
  logic            step_rise;
  logic            halt_eff;
  logic            bp_hit;
  logic [PC_W-1:0] pc_next;

  assign step_rise = step_i & ~step_q;
  // A request arriving in the same cycle as a decision point is honoured
  // immediately, not one cycle late.
  assign halt_eff  = halt_pending | halt_req_i;
  // Breakpoint is checked against the PC the instruction is about to advance to.
  assign pc_next   = pc_i + PC_W'(1);
  assign bp_hit    = bp_en_i & (pc_next == bp_addr_i);

  // State, mode, halt request latch, step edge register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mode         <= 1'b0;
      halt_pending <= 1'b0;
      step_q       <= 1'b0;
    end else begin
      state  <= state_n;
      mode   <= mode_n;
      step_q <= step_i;
      // Clearing on entry wins so a one-shot request cannot re-halt after resume.
      if (state_n == HALTED && state != HALTED) halt_pending <= 1'b0;
      else if (halt_req_i)                      halt_pending <= 1'b1;
    end
  end

  // Retired-instruction counter, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         instr_count_o <= '0;
    else if (state == WRITEBACK && ~&instr_count_o)  instr_count_o <= instr_count_o + COUNT_W'(1);
  end

  // Next-state and mode selection.
  always_comb begin
    state_n = state;
    mode_n  = mode;
    case (state)
      IDLE: begin
        if (halt_eff)       state_n = HALTED;
        else if (run_i)     begin state_n = FETCH; mode_n = 1'b1; end
        else if (step_rise) begin state_n = FETCH; mode_n = 1'b0; end
      end
      FETCH:     state_n = DECODE;
      DECODE:    state_n = EXECUTE;
      EXECUTE:   state_n = WRITEBACK;
      WRITEBACK: begin
        if (halt_eff || bp_hit) state_n = HALTED;
        else if (mode && run_i) state_n = FETCH;
        else                    state_n = IDLE;
      end
      HALTED: begin
        if (resume_i)       state_n = IDLE;
        else if (step_rise) begin state_n = FETCH; mode_n = 1'b0; end
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath controls decoded straight from the state register.
  always_comb begin
    ir_load_o = (state == FETCH);
    pc_en_o   = (state == WRITEBACK);
    reg_we_o  = (state == WRITEBACK) & ctrl_regwrite_i;
    busy_o    = (state == FETCH) || (state == DECODE) ||
                (state == EXECUTE) || (state == WRITEBACK);
    halted_o  = (state == HALTED);
    state_o   = state;
  end

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench for cpu_step_controller with a simple PC register model.
module tb_cpu_step_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_i, step_i, halt_req_i, resume_i, bp_en_i, ctrl_regwrite_i;
  logic [7:0]  bp_addr_i, pc_i;
  logic        pc_en_o, ir_load_o, reg_we_o, busy_o, halted_o;
  logic [2:0]  state_o;
  logic [15:0] instr_count_o;
  logic        s_pc_en, s_ir_load, s_reg_we, s_busy, s_halted;
  logic [2:0]  s_state;
  logic [3:0]  s_count;

  logic       pc_set;
  logic [7:0] pc_init;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_step_controller #(.PC_W(8), .COUNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .run_i(run_i), .step_i(step_i),
    .halt_req_i(halt_req_i), .resume_i(resume_i), .bp_en_i(bp_en_i),
    .bp_addr_i(bp_addr_i), .pc_i(pc_i), .ctrl_regwrite_i(ctrl_regwrite_i),
    .pc_en_o(pc_en_o), .ir_load_o(ir_load_o), .reg_we_o(reg_we_o),
    .busy_o(busy_o), .halted_o(halted_o), .state_o(state_o),
    .instr_count_o(instr_count_o)
  );

  cpu_step_controller #(.PC_W(8), .COUNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .run_i(run_i), .step_i(step_i),
    .halt_req_i(halt_req_i), .resume_i(resume_i), .bp_en_i(bp_en_i),
    .bp_addr_i(bp_addr_i), .pc_i(pc_i), .ctrl_regwrite_i(ctrl_regwrite_i),
    .pc_en_o(s_pc_en), .ir_load_o(s_ir_load), .reg_we_o(s_reg_we),
    .busy_o(s_busy), .halted_o(s_halted), .state_o(s_state),
    .instr_count_o(s_count)
  );

  // PC register model: loads on request, otherwise advances on pc_en_o.
  always @(posedge clk) begin
    if (pc_set)       pc_i <= pc_init;
    else if (pc_en_o) pc_i <= pc_i + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one cycle; return at the falling edge for sampling and driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [7:0] pc0);
    rst = 1'b1; run_i = 0; step_i = 0; halt_req_i = 0; resume_i = 0;
    pc_set = 1'b1; pc_init = pc0;
    tick(); tick();
    rst = 1'b0; pc_set = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run_i = 0; step_i = 0; halt_req_i = 0; resume_i = 0;
    bp_en_i = 0; bp_addr_i = 8'h00; ctrl_regwrite_i = 0;
    pc_set = 1'b1; pc_init = 8'h00; pc_i = 8'h00;

    // Reset state
    tick(); tick();
    chk("rst_state", state_o, 0);
    chk("rst_outs", {pc_en_o, ir_load_o, reg_we_o, busy_o, halted_o}, 0);
    chk("rst_count", instr_count_o, 0);
    rst = 1'b0; pc_set = 1'b0;

    // Continuous run: 12 cycles, three instructions
    run_i = 1'b1; ctrl_regwrite_i = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("run_ir%0d", c), ir_load_o, (c % 4) == 1);
      chk($sformatf("run_pc%0d", c), pc_en_o, (c % 4) == 0);
      chk($sformatf("run_we%0d", c), reg_we_o, (c % 4) == 0);
    end
    run_i = 1'b0;
    tick();
    chk("run_idle", state_o, 0);
    chk("run_count", instr_count_o, 3);
    chk("run_pc", pc_i, 3);

    // Single step with step_i held for 10 cycles
    do_reset(8'h00);
    ctrl_regwrite_i = 1'b1; step_i = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk($sformatf("step_st%0d", c), state_o, (c <= 4) ? c : 0);
      chk($sformatf("step_we%0d", c), reg_we_o, c == 4);
    end
    chk("step_count", instr_count_o, 1);
    // Second step with RegWrite low: no register write
    step_i = 1'b0; ctrl_regwrite_i = 1'b0; tick();
    step_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("step2_st%0d", c), state_o, c);
      chk($sformatf("step2_we%0d", c), reg_we_o, 0);
    end
    step_i = 1'b0; tick();
    chk("step2_count", instr_count_o, 2);

    // Breakpoint at 0x03 while running from 0
    do_reset(8'h00);
    bp_en_i = 1'b1; bp_addr_i = 8'h03; run_i = 1'b1;
    for (int c = 1; c <= 12; c++) tick();
    tick();
    chk("bp_halted", halted_o, 1);
    chk("bp_state", state_o, 5);
    chk("bp_count", instr_count_o, 3);
    tick();
    chk("bp_stays", halted_o, 1);
    // Step off the breakpoint
    run_i = 1'b0; step_i = 1'b1;
    tick();
    chk("bpstep_fetch", ir_load_o, 1);
    tick(); tick(); tick();
    chk("bpstep_wb", pc_en_o, 1);
    tick();
    chk("bpstep_idle", state_o, 0);
    chk("bpstep_nohalt", halted_o, 0);
    chk("bpstep_count", instr_count_o, 4);
    step_i = 1'b0;

    // Breakpoint with PC wrap-around 0xFF -> 0x00
    do_reset(8'hFF);
    bp_en_i = 1'b1; bp_addr_i = 8'h00; run_i = 1'b1;
    for (int c = 1; c <= 5; c++) tick();
    chk("wrap_halted", halted_o, 1);
    chk("wrap_count", instr_count_o, 1);
    chk("wrap_pc", pc_i, 8'h00);
    run_i = 1'b0; bp_en_i = 1'b0;

    // Halt request pulsed in DECODE while running
    do_reset(8'h00);
    run_i = 1'b1;
    tick(); tick();
    chk("hm_decode", state_o, 2);
    halt_req_i = 1'b1;
    tick();
    halt_req_i = 1'b0;
    chk("hm_exec", state_o, 3);
    tick();
    chk("hm_wb_pcen", pc_en_o, 1);
    tick();
    chk("hm_halted", halted_o, 1);
    chk("hm_count", instr_count_o, 1);
    run_i = 1'b0; resume_i = 1'b1;
    tick();
    resume_i = 1'b0;
    chk("hm_resume", state_o, 0);
    tick();
    chk("hm_stay_idle", state_o, 0);
    // Halt from IDLE with run asserted simultaneously
    halt_req_i = 1'b1; run_i = 1'b1;
    tick();
    halt_req_i = 1'b0; run_i = 1'b0;
    chk("hm_idle_halt", state_o, 5);
    // Resume and step edge together: resume wins
    resume_i = 1'b1; step_i = 1'b1;
    tick();
    resume_i = 1'b0;
    chk("hm_rs_idle", state_o, 0);
    tick();
    chk("hm_rs_nofetch", ir_load_o, 0);
    chk("hm_rs_state", state_o, 0);
    chk("hm_rs_count", instr_count_o, 1);
    step_i = 1'b0;

    // Reset while in EXECUTE abandons the instruction
    do_reset(8'h00);
    run_i = 1'b1;
    tick(); tick(); tick();
    chk("rx_exec", state_o, 3);
    rst = 1'b1;
    #1;
    chk("rx_async", state_o, 0);
    run_i = 1'b0;
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("rx_nopc%0d", c), pc_en_o, 0);
    end
    chk("rx_count", instr_count_o, 0);
    chk("rx_pc", pc_i, 0);

    // Saturation: 17 instructions, 4-bit counter holds at 15
    do_reset(8'h00);
    run_i = 1'b1;
    for (int c = 1; c <= 68; c++) tick();
    run_i = 1'b0;
    tick();
    chk("sat_count4", s_count, 15);
    chk("sat_count16", instr_count_o, 17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
